// File: rtl/dc_motor_pwm.sv
// Multi-channel H-bridge PWM driver: sign-magnitude PWM, soft ramp, safe reversal,
// dead-time insertion and active brake per channel, sharing one PWM counter and ramp prescaler.
module dc_motor_pwm #(
    parameter int CH       = 2,
    parameter int CNT_W    = 8,
    parameter int DEAD     = 4,
    parameter int RAMP_DIV = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CH-1:0]       halt,
    input  logic [CH-1:0]       brake,
    input  logic [CH-1:0]       dir,
    input  logic [CH*CNT_W-1:0] duty,
    output logic [2*CH-1:0]     MA,
    output logic [CH-1:0]       at_speed
);

    localparam int PS_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DC_W = (DEAD > 1) ? $clog2(DEAD) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(RAMP_DIV - 1);
    localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEAD - 1);

    typedef enum logic [1:0] {
        ST_COAST = 2'd0,
        ST_DEAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_BRAKE = 2'd3
    } state_t;

    // Shared timebase
    logic [CNT_W-1:0] r_cnt;
    logic [PS_W-1:0]  r_presc;
    logic             w_tick;

    // Per-channel state
    state_t           r_state   [CH];
    state_t           r_pend    [CH];
    logic [CNT_W-1:0] r_cur     [CH];
    logic [CNT_W-1:0] r_cmp     [CH];
    logic [DC_W-1:0]  r_dead    [CH];
    logic [CH-1:0]    r_run_dir;

    // Next-state and decode
    state_t           w_state_nx [CH];
    state_t           w_pend_nx  [CH];
    logic [CNT_W-1:0] w_cur_nx   [CH];
    logic [DC_W-1:0]  w_dead_nx  [CH];
    logic [CNT_W-1:0] w_duty     [CH];
    logic [CNT_W-1:0] w_target   [CH];
    logic [CH-1:0]    w_dir_nx;
    logic [CH-1:0]    w_pwm;
    logic [2*CH-1:0]  w_ma_nx;
    logic [CH-1:0]    w_as_nx;

    assign w_tick = (r_presc == PS_LAST);

    // NOTE: sequential state is always assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_presc <= '0;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latches are inferred.
        w_ma_nx  = '0;
        w_as_nx  = '0;
        w_pwm    = '0;
        w_dir_nx = r_run_dir;
        for (int i = 0; i < CH; i++) begin
            w_duty[i]     = duty[i*CNT_W +: CNT_W];
            w_target[i]   = (dir[i] == r_run_dir[i]) ? w_duty[i] : '0;
            w_pwm[i]      = (r_cnt < r_cmp[i]);
            w_state_nx[i] = r_state[i];
            w_pend_nx[i]  = r_pend[i];
            w_cur_nx[i]   = r_cur[i];
            w_dead_nx[i]  = r_dead[i];

            case (r_state[i])
                ST_COAST: begin
                    w_cur_nx[i] = '0;
                    if (!halt[i] && brake[i]) begin
                        w_pend_nx[i]  = ST_BRAKE;
                        w_state_nx[i] = ST_DEAD;
                    end else if (!halt[i] && (w_duty[i] != '0)) begin
                        w_pend_nx[i]  = ST_RUN;
                        w_dir_nx[i]   = dir[i];
                        w_state_nx[i] = ST_DEAD;
                    end
                end

                ST_DEAD: begin
                    if (halt[i]) begin
                        w_state_nx[i] = ST_COAST;
                        w_dead_nx[i]  = '0;
                    end else if (r_dead[i] == DC_LAST) begin
                        w_state_nx[i] = r_pend[i];
                        w_dead_nx[i]  = '0;
                    end else begin
                        w_dead_nx[i]  = r_dead[i] + 1'b1;
                    end
                end

                ST_RUN: begin
                    w_ma_nx[2*i +: 2] = r_run_dir[i] ? {w_pwm[i], 1'b0} : {1'b0, w_pwm[i]};
                    w_as_nx[i]        = (r_cur[i] == w_duty[i]) && (r_run_dir[i] == dir[i]);
                    if (halt[i]) begin
                        w_state_nx[i] = ST_COAST;
                        w_cur_nx[i]   = '0;
                    end else if (brake[i]) begin
                        w_cur_nx[i]   = '0;
                        w_pend_nx[i]  = ST_BRAKE;
                        w_state_nx[i] = ST_DEAD;
                    end else if ((dir[i] != r_run_dir[i]) && (r_cur[i] == '0)) begin
                        // Reversal only once the ramp has brought the bridge to zero duty
                        w_pend_nx[i]  = ST_RUN;
                        w_dir_nx[i]   = dir[i];
                        w_state_nx[i] = ST_DEAD;
                    end else if (w_tick) begin
                        if (r_cur[i] < w_target[i]) begin
                            w_cur_nx[i] = r_cur[i] + 1'b1;
                        end else if (r_cur[i] > w_target[i]) begin
                            w_cur_nx[i] = r_cur[i] - 1'b1;
                        end
                    end
                end

                ST_BRAKE: begin
                    w_ma_nx[2*i +: 2] = 2'b11;
                    if (halt[i] || !brake[i]) begin
                        w_state_nx[i] = ST_COAST;
                    end
                end

                default: begin
                    w_state_nx[i] = ST_COAST;
                end
            endcase

            // Emergency coast overrides the drive on the very next edge
            if (halt[i]) begin
                w_ma_nx[2*i +: 2] = 2'b00;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: these per-channel arrays are control state, not storage, so every entry is cleared on reset.
            for (int i = 0; i < CH; i++) begin
                r_state[i] <= ST_COAST;
                r_pend[i]  <= ST_COAST;
                r_cur[i]   <= '0;
                r_cmp[i]   <= '0;
                r_dead[i]  <= '0;
            end
            r_run_dir <= '0;
            MA        <= '0;
            at_speed  <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                r_state[i] <= w_state_nx[i];
                r_pend[i]  <= w_pend_nx[i];
                r_cur[i]   <= w_cur_nx[i];
                r_dead[i]  <= w_dead_nx[i];
                // Compare value is only refreshed at the period boundary; cleared outside RUN so a restart never reuses a stale width
                if (r_state[i] != ST_RUN) begin
                    r_cmp[i] <= '0;
                end else if (r_cnt == '0) begin
                    r_cmp[i] <= r_cur[i];
                end
            end
            r_run_dir <= w_dir_nx;
            MA        <= w_ma_nx;
            at_speed  <= w_as_nx;
        end
    end

endmodule
